// File: rtl/round_sequencer.sv
// Game sequencer for the symbol-counting game: IDLE -> (GEN -> ANSWER -> POST) x NUM_ROUNDS -> OVER,
// timed by a 1 Hz tick, scoring each round by comparing the player's count with the generated count.
module round_sequencer #(
  parameter int GEN_SECONDS    = 10,
  parameter int ANSWER_SECONDS = 5,
  parameter int POST_SECONDS   = 3,
  parameter int NUM_ROUNDS     = 5
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       tick1Hz,
  input  logic       startBtn,
  input  logic       genDone,
  input  logic [6:0] symbolCount,
  input  logic [6:0] userCount,
  output logic       startGen,
  output logic       stopGen,
  output logic       answerSig,
  output logic       userCountEn,
  output logic       clearCount,
  output logic [2:0] phase,
  output logic [3:0] secondsLeft,
  output logic [3:0] roundNum,
  output logic [3:0] score,
  output logic       lastCorrect,
  output logic       gameOver
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_ANSWER = 3'd2,
    S_POST   = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [3:0] GEN_SEC    = 4'(GEN_SECONDS);
  localparam logic [3:0] ANSWER_SEC = 4'(ANSWER_SECONDS);
  localparam logic [3:0] POST_SEC   = 4'(POST_SECONDS);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state, state_n;
  logic       start_prev;
  logic       start_rise;
  logic       expired;
  logic       start_gen_n, stop_gen_n, answer_sig_n, clear_count_n;
  logic [3:0] seconds_n, round_n, score_n;
  logic       last_n;

  // startPrev resets high so a button held through reset never starts a game.
  assign start_rise = startBtn & ~start_prev;
  assign expired    = tick1Hz && (secondsLeft == 4'd1);
  assign phase      = state;

  always_comb begin
    state_n       = state;
    seconds_n     = secondsLeft;
    round_n       = roundNum;
    score_n       = score;
    last_n        = lastCorrect;
    start_gen_n   = 1'b0;
    stop_gen_n    = 1'b0;
    answer_sig_n  = 1'b0;
    clear_count_n = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_n       = S_GEN;
          start_gen_n   = 1'b1;
          clear_count_n = 1'b1;
          round_n       = 4'd1;
          score_n       = 4'd0;
          last_n        = 1'b0;
          seconds_n     = GEN_SEC;
        end
      end
      S_GEN: begin
        // An early finish beats a simultaneous timeout, so no stop pulse is sent.
        if (genDone || expired) begin
          state_n      = S_ANSWER;
          stop_gen_n   = ~genDone;
          answer_sig_n = 1'b1;
          seconds_n    = ANSWER_SEC;
        end else if (tick1Hz) begin
          seconds_n = secondsLeft - 4'd1;
        end
      end
      S_ANSWER: begin
        if (expired) begin
          state_n   = S_POST;
          last_n    = (userCount == symbolCount);
          seconds_n = POST_SEC;
          if ((userCount == symbolCount) && (score != 4'd15)) begin
            score_n = score + 4'd1;
          end
        end else if (tick1Hz) begin
          seconds_n = secondsLeft - 4'd1;
        end
      end
      S_POST: begin
        if (expired) begin
          if (roundNum == LAST_ROUND) begin
            state_n   = S_OVER;
            seconds_n = 4'd0;
          end else begin
            state_n       = S_GEN;
            round_n       = roundNum + 4'd1;
            start_gen_n   = 1'b1;
            clear_count_n = 1'b1;
            seconds_n     = GEN_SEC;
          end
        end else if (tick1Hz) begin
          seconds_n = secondsLeft - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      start_prev  <= 1'b1;
      startGen    <= 1'b0;
      stopGen     <= 1'b0;
      answerSig   <= 1'b0;
      userCountEn <= 1'b0;
      clearCount  <= 1'b0;
      secondsLeft <= 4'd0;
      roundNum    <= 4'd0;
      score       <= 4'd0;
      lastCorrect <= 1'b0;
      gameOver    <= 1'b0;
    end else begin
      state       <= state_n;
      start_prev  <= startBtn;
      startGen    <= start_gen_n;
      stopGen     <= stop_gen_n;
      answerSig   <= answer_sig_n;
      userCountEn <= (state_n == S_ANSWER);
      clearCount  <= clear_count_n;
      secondsLeft <= seconds_n;
      roundNum    <= round_n;
      score       <= score_n;
      lastCorrect <= last_n;
      gameOver    <= (state_n == S_OVER);
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed vector table, hand-written game sequences and
// randomized stimulus, all compared against a per-cycle behavioural model of the game.
module tb_round_sequencer;

  localparam int GEN_S = 10;
  localparam int ANS_S = 5;
  localparam int PST_S = 3;
  localparam int ROUNDS = 5;

  logic       Clk100M = 1'b0;
  logic       Reset;
  logic       tick1Hz, startBtn, genDone;
  logic [6:0] symbolCount, userCount;
  logic       startGen, stopGen, answerSig, userCountEn, clearCount;
  logic [2:0] phase;
  logic [3:0] secondsLeft, roundNum, score;
  logic       lastCorrect, gameOver;

  round_sequencer #(
    .GEN_SECONDS(GEN_S), .ANSWER_SECONDS(ANS_S), .POST_SECONDS(PST_S), .NUM_ROUNDS(ROUNDS)
  ) dut (
    .Clk100M(Clk100M), .Reset(Reset), .tick1Hz(tick1Hz), .startBtn(startBtn),
    .genDone(genDone), .symbolCount(symbolCount), .userCount(userCount),
    .startGen(startGen), .stopGen(stopGen), .answerSig(answerSig),
    .userCountEn(userCountEn), .clearCount(clearCount), .phase(phase),
    .secondsLeft(secondsLeft), .roundNum(roundNum), .score(score),
    .lastCorrect(lastCorrect), .gameOver(gameOver)
  );

  // clock / reset
  always #5 Clk100M = ~Clk100M;

  // behavioural model: game phase, countdown and score kept as plain integers
  int m_phase, m_secs, m_round, m_score;
  bit m_last, m_prev;
  bit m_sg, m_sp, m_as, m_cc;

  int n_checks = 0;
  int n_pass   = 0;
  logic [25:0] exp_q[$];

  logic       btn_lvl = 1'b0;
  logic [6:0] sym_v = 7'd0;
  logic [6:0] usr_v = 7'd0;

  function automatic logic [25:0] pack(input logic sg, sp, as, en, cc, input logic [2:0] ph,
                                       input logic [3:0] s, r, sc, input logic lc, go);
    return {sg, sp, as, en, cc, ph, s, r, sc, lc, go};
  endfunction

  task automatic model_step(input logic rst, tk, gd, btn, input logic [6:0] sym, usr);
    bit rise;
    m_sg = 0; m_sp = 0; m_as = 0; m_cc = 0;
    if (rst) begin
      m_phase = 0; m_secs = 0; m_round = 0; m_score = 0; m_last = 0; m_prev = 1;
      return;
    end
    rise = btn && !m_prev;
    m_prev = btn;
    if (m_phase == 0 || m_phase == 4) begin
      if (rise) begin
        m_phase = 1; m_sg = 1; m_cc = 1; m_round = 1; m_score = 0; m_last = 0; m_secs = GEN_S;
      end
    end else if (m_phase == 1 && gd) begin
      m_phase = 2; m_as = 1; m_secs = ANS_S;
    end else if (tk && m_secs > 1) begin
      m_secs = m_secs - 1;
    end else if (tk) begin
      if (m_phase == 1) begin
        m_phase = 2; m_as = 1; m_sp = 1; m_secs = ANS_S;
      end else if (m_phase == 2) begin
        m_phase = 3; m_secs = PST_S;
        m_last = (sym == usr);
        if (m_last && m_score < 15) m_score = m_score + 1;
      end else if (m_round == ROUNDS) begin
        m_phase = 4; m_secs = 0;
      end else begin
        m_phase = 1; m_round = m_round + 1; m_sg = 1; m_cc = 1; m_secs = GEN_S;
      end
    end
  endtask

  function automatic logic [25:0] model_out();
    return pack(m_sg, m_sp, m_as, m_phase == 2, m_cc, 3'(m_phase), 4'(m_secs), 4'(m_round),
                4'(m_score), m_last, m_phase == 4);
  endfunction

  function automatic logic [25:0] dut_out();
    return pack(startGen, stopGen, answerSig, userCountEn, clearCount, phase, secondsLeft,
                roundNum, score, lastCorrect, gameOver);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // driver: apply one cycle of inputs, then compare every output against the model
  task automatic step(input logic rst, tk, gd);
    logic [25:0] exp;
    Reset = rst; tick1Hz = tk; genDone = gd; startBtn = btn_lvl;
    symbolCount = sym_v; userCount = usr_v;
    model_step(rst, tk, gd, btn_lvl, sym_v, usr_v);
    exp_q.push_back(model_out());
    @(posedge Clk100M); #1;
    exp = exp_q.pop_front();
    check("model", 32'(dut_out()), 32'(exp));
  endtask

  task automatic drive(input logic tk, input logic gd);
    step(1'b0, tk, gd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
    end
  endtask

  task automatic press();
    btn_lvl = 1'b0; drive(1'b0, 1'b0);
    btn_lvl = 1'b1; drive(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       btn;
    logic       tk;
    logic [2:0] ph;
    logic [3:0] secs;
    logic [3:0] rnd;
    logic       sg;
    logic       cc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'd0, 4'd0,  4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'd0, 4'd0,  4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 4'd0,  4'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'd1, 4'd10, 4'd1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 3'd1, 4'd10, 4'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 3'd1, 4'd9,  4'd1, 1'b0, 1'b0};

    // reset with the button held high
    btn_lvl = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_pulses", 32'({startGen, stopGen, answerSig, clearCount, userCountEn}), 32'd0);
    check("reset_counts", 32'({secondsLeft, roundNum, score, lastCorrect, gameOver}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      btn_lvl = vecs[i].btn;
      drive(vecs[i].tk, 1'b0);
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
      check($sformatf("vec%0d_secs", i), 32'(secondsLeft), 32'(vecs[i].secs));
      check($sformatf("vec%0d_round", i), 32'(roundNum), 32'(vecs[i].rnd));
      check($sformatf("vec%0d_start", i), 32'({startGen, clearCount}), 32'({vecs[i].sg, vecs[i].cc}));
    end

    // GEN timeout: eight more ticks reach 1, the next one forces a stop
    ticks(8);
    check("gen_secs_one", 32'(secondsLeft), 32'd1);
    drive(1'b1, 1'b0);
    check("timeout_pulses", 32'({stopGen, answerSig, userCountEn}), 32'b111);
    check("timeout_phase", 32'({phase, secondsLeft}), 32'({3'd2, 4'd5}));
    drive(1'b0, 1'b0);
    check("pulses_one_cycle", 32'({stopGen, answerSig, userCountEn}), 32'b001);

    // ANSWER correct
    sym_v = 7'd23; usr_v = 7'd23;
    ticks(ANS_S - 1);
    drive(1'b1, 1'b0);
    check("correct_post", 32'({phase, lastCorrect, score, userCountEn}), 32'({3'd3, 1'b1, 4'd1, 1'b0}));
    ticks(PST_S - 1);
    drive(1'b1, 1'b0);
    check("round2_start", 32'({phase, roundNum, startGen, clearCount, secondsLeft}),
          32'({3'd1, 4'd2, 1'b1, 1'b1, 4'd10}));

    // genDone on the terminal tick: early finish wins
    ticks(GEN_S - 1);
    drive(1'b1, 1'b1);
    check("gd_tick_tie", 32'({phase, stopGen, answerSig}), 32'({3'd2, 1'b0, 1'b1}));

    // ANSWER wrong
    usr_v = 7'd22;
    ticks(ANS_S - 1);
    drive(1'b1, 1'b0);
    check("wrong_post", 32'({phase, lastCorrect, score}), 32'({3'd3, 1'b0, 4'd1}));
    ticks(PST_S);
    check("round3_gen", 32'({phase, roundNum}), 32'({3'd1, 4'd3}));
    drive(1'b0, 1'b1);
    ticks(2);
    check("round3_answer", 32'(phase), 32'd2);

    // reset mid-answer
    step(1'b1, 1'b0, 1'b0);
    check("midreset_state", 32'({phase, roundNum, score, userCountEn}), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    check("midreset_pulses", 32'({startGen, stopGen, answerSig, clearCount}), 32'd0);

    // full game, all correct, with ignored button presses and stray genDone
    press();
    for (int r = 0; r < ROUNDS; r++) begin
      press();
      ticks(3);
      drive(1'b0, 1'b1);
      sym_v = 7'($urandom_range(0, 127)); usr_v = sym_v;
      press();
      drive(1'b0, 1'b1);
      ticks(ANS_S);
      press();
      ticks(PST_S);
    end
    check("game_over", 32'({phase, gameOver, score, secondsLeft}), 32'({3'd4, 1'b1, 4'd5, 4'd0}));
    drive(1'b0, 1'b1);
    press();
    check("new_game", 32'({phase, score, roundNum, gameOver}), 32'({3'd1, 4'd0, 4'd1, 1'b0}));

    // randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_lvl = ~btn_lvl;
      sym_v = 7'($urandom_range(0, 127));
      usr_v = ($urandom_range(0, 1) == 1) ? sym_v : 7'($urandom_range(0, 127));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
